// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg
//   Shared definitions for the bit-serial adder: controller state encoding
//   and the default operand width.
package serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_t;

endpackage

// File: rtl/serial_adder_fa.sv
// Single-bit full-adder cells used by serial_adder.
//   structuralFullAdder : gate-level cell (XOR/AND/OR), the default cell.
//   behavioralFullAdder : arithmetic cell, drop-in replacement for fast sim.
// Ports (identical order in both):
//   a, b  : operand bits
//   cin   : carry in
//   s     : sum bit
//   cout  : carry out
module structuralFullAdder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic axb;
    logic gen;
    logic prop;

    assign axb  = a ^ b;
    assign s    = axb ^ cin;
    assign gen  = a & b;
    assign prop = axb & cin;
    assign cout = gen | prop;

endmodule

module behavioralFullAdder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign {cout, s} = {1'b0, a} + {1'b0, b} + {1'b0, cin};

endmodule

// File: rtl/serial_adder.sv
// serial_adder
//   Bit-serial WIDTH-bit adder. One operand bit pair per clock passes through
//   a single full-adder cell; the cell's carry out is registered and fed back
//   as the next bit's carry in. start/busy/done handshake to the controller.
// Ports:
//   clk      : system clock, rising edge
//   rst_n    : asynchronous active-low reset
//   start    : request new addition (accepted in IDLE or DONE)
//   a, b     : operands, captured on the accepted start edge
//   cin      : initial carry, captured on the accepted start edge
//   busy     : high while the addition is running
//   done     : one-cycle pulse, result registers just updated
//   sum      : last completed result
//   cout     : carry out of the MSB for the last completed result
//   overflow : two's-complement overflow for the last completed result
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int CW = $clog2(WIDTH);

    state_t           state;
    state_t           state_nxt;
    logic             load;
    logic             last;

    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic [WIDTH-1:0] psum;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic             fa_s;
    logic             fa_c;

    structuralFullAdder u_fa (
        .a    (opa[0]),
        .b    (opb[0]),
        .cin  (carry),
        .s    (fa_s),
        .cout (fa_c)
    );

    assign last = (cnt == CW'(WIDTH - 1));

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (last) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                // DONE accepts start exactly like IDLE for back-to-back ops.
                if (start) begin
                    load      = 1'b1;
                    state_nxt = S_RUN;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opa      <= '0;
            opb      <= '0;
            psum     <= '0;
            carry    <= 1'b0;
            cnt      <= '0;
            sum      <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
        end else if (load) begin
            opa   <= a;
            opb   <= b;
            carry <= cin;
            cnt   <= '0;
        end else if (state == S_RUN) begin
            opa   <= opa >> 1;
            opb   <= opb >> 1;
            psum  <= {fa_s, psum[WIDTH-1:1]};
            carry <= fa_c;
            cnt   <= cnt + CW'(1);
            if (last) begin
                sum      <= {fa_s, psum[WIDTH-1:1]};
                cout     <= fa_c;
                // carry currently holds the carry into the MSB.
                overflow <= carry ^ fa_c;
            end
        end
    end

    assign busy = (state == S_RUN);
    assign done = (state == S_DONE);

endmodule

// File: tb/tb_serial_adder.sv
module tb_serial_adder;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         overflow;

    serial_adder #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .a        (a),
        .b        (b),
        .cin      (cin),
        .busy     (busy),
        .done     (done),
        .sum      (sum),
        .cout     (cout),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #200 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] s;
        logic         c;
        logic         v;
        int           cyc;
    } exp_t;

    exp_t q[$];

    int checks = 0;
    int errors = 0;

    logic [W-1:0] last_s;
    logic         last_c;
    logic         last_v;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual %0h required %0h (time %0t)", name, act, req, $time);
        end
    endfunction

    // Reference: plain integer arithmetic on the operands.
    function automatic exp_t model(logic [W-1:0] x, logic [W-1:0] y, logic ci, int c);
        exp_t e;
        logic [W:0] t;
        t = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
        e.s = t[W-1:0];
        e.c = t[W];
        e.v = (x[W-1] == y[W-1]) && (t[W-1] != x[W-1]);
        e.cyc = c;
        return e;
    endfunction

    task automatic step();
        @(negedge clk);
        #10;
    endtask

    // Called just after a negedge; start is sampled at the next posedge.
    task automatic issue(logic [W-1:0] x, logic [W-1:0] y, logic ci);
        a = x;
        b = y;
        cin = ci;
        start = 1'b1;
        q.push_back(model(x, y, ci, cyc + 1 + W));
        step();
        start = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
        cin = 1'($urandom);
    endtask

    task automatic wait_idle();
        repeat (W + 2) step();
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                chk("reset_sum", 64'(sum), 64'(0));
                chk("reset_flags", 64'({busy, done, cout, overflow}), 64'(0));
                last_s = '0;
                last_c = 1'b0;
                last_v = 1'b0;
            end else if (done) begin
                if (q.size() == 0) begin
                    chk("unexpected_done", 64'(1), 64'(0));
                end else begin
                    e = q.pop_front();
                    chk("done_cycle", 64'(cyc), 64'(e.cyc));
                    chk("sum", 64'(sum), 64'(e.s));
                    chk("cout", 64'(cout), 64'(e.c));
                    chk("overflow", 64'(overflow), 64'(e.v));
                    chk("busy_in_done", 64'(busy), 64'(0));
                    last_s = e.s;
                    last_c = e.c;
                    last_v = e.v;
                end
            end else begin
                chk("hold_result", 64'({sum, cout, overflow}), 64'({last_s, last_c, last_v}));
            end
        end
    endtask

    task automatic driver();
        int nb;
        rst_n = 1'b0;
        start = 1'b0;
        a = '0;
        b = '0;
        cin = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
        step();

        // Basic add with busy-length check.
        issue(8'h35, 8'h4A, 1'b0);
        nb = 0;
        for (int i = 0; i < W + 2; i++) begin
            if (busy) nb++;
            step();
        end
        chk("busy_cycles", 64'(nb), 64'(W));

        // Carry / wrap and signed overflow corners.
        issue(8'hFF, 8'h01, 1'b0); wait_idle();
        issue(8'h00, 8'h00, 1'b1); wait_idle();
        issue(8'h7F, 8'h01, 1'b0); wait_idle();
        issue(8'h80, 8'h80, 1'b0); wait_idle();
        issue(8'hFF, 8'hFF, 1'b1); wait_idle();

        // start pulsed during RUN is ignored.
        issue(8'h12, 8'h34, 1'b0);
        repeat (2) step();
        a = 8'hEE;
        b = 8'hEE;
        cin = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        wait_idle();

        // Back-to-back: second start issued in the DONE cycle.
        issue(8'h21, 8'h43, 1'b1);
        repeat (W) step();
        issue(8'hC0, 8'h50, 1'b0);
        wait_idle();

        // Reset mid-operation aborts with no done pulse.
        issue(8'h55, 8'h66, 1'b1);
        repeat (3) step();
        #50;
        rst_n = 1'b0;
        q.delete();
        #1;
        chk("async_reset_sum", 64'(sum), 64'(0));
        chk("async_reset_flags", 64'({busy, done, cout, overflow}), 64'(0));
        step();
        rst_n = 1'b1;
        step();
        issue(8'h10, 8'h20, 1'b0);
        wait_idle();

        // Randomized operations, sometimes back-to-back.
        for (int i = 0; i < 24; i++) begin
            issue(W'($urandom), W'($urandom), 1'($urandom));
            if ($urandom_range(1, 0) == 1) begin
                repeat (W) step();
            end else begin
                repeat (W + 1 + $urandom_range(3, 0)) step();
            end
        end

        // Drain with a bounded wait.
        for (int i = 0; i < 4 * W && q.size() != 0; i++) step();
        chk("queue_drained", 64'(q.size()), 64'(0));
    endtask

    initial begin
        fork
            monitor();
            driver();
        join_any
        disable fork;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial adder/controller that computes a WIDTH-bit sum by feeding one operand bit pair per clock into a single full-adder cell.
- A registered carry loops the cell's carryout back into its carryin on the next cycle.
- Sits directly upstream of the full-adder cell and owns all sequencing, operand buffering and result assembly.
- Trades latency for area in the arithmetic datapath, and exposes a start/busy/done handshake to the surrounding control logic.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 2..32.

Ports:
- clk  input  1  single system clock; all state updates on the rising edge
- rst_n  input  1  reset, asynchronous, active-low
- start  input  1  request a new addition; sampled on a rising edge of clk
- a  input  WIDTH  operand A; captured on the accepted start edge
- b  input  WIDTH  operand B; captured on the accepted start edge
- cin  input  1  initial carry-in; captured on the accepted start edge
- busy  output  1  high while an addition is in progress (state RUN)
- done  output  1  one-cycle pulse: result registers just updated
- sum  output  WIDTH  result; holds the last completed result
- cout  output  1  carry out of bit WIDTH-1 for the last completed result
- overflow  output  1  two's-complement overflow for the last completed result

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low. rst_n low forces:
  - state = IDLE;
  - busy, done, sum, cout, overflow = 0;
  - operand shift registers, carry flop and bit counter = 0.
- States are IDLE, RUN and DONE, encoded as 2 bits.
- IDLE:
  - start=1 loads opA<=a, opB<=b, carry<=cin, cnt<=0, and moves to RUN.
  - start=0 stays in IDLE.
- RUN, each edge:
  - The full-adder cell sees (opA[0], opB[0], carry).
  - The cell's sum bit shifts into the MSB of the partial-sum register; opA and opB shift right by 1.
  - carry <= carryout; cnt <= cnt+1.
  - start is ignored while in RUN.
- Last step (cnt == WIDTH-1):
  - sum <= final partial sum; cout <= carryout; overflow <= carry XOR carryout (carry into MSB XOR carry out of MSB).
  - done <= 1; state moves to DONE.
- DONE:
  - Lasts exactly one cycle; done returns to 0 on the next edge.
  - start=1 in DONE is accepted exactly as in IDLE, so back-to-back operations are allowed. Otherwise the state moves to IDLE.
- Latency: start sampled at edge E0; RUN steps occur at E1..E_WIDTH; done is high during the cycle after E_WIDTH.
  - busy is high from after E0 until E_WIDTH.
  - Start-to-start throughput is WIDTH+1 cycles.
- Result stability:
  - sum, cout and overflow change only at the last RUN step.
  - They hold their values through RUN of the next operation and through IDLE.
- Arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1). There are no saturation modes.
- Operand changes after the accepted start edge have no effect on the operation in flight.
- Reset mid-operation aborts immediately:
  - done is not asserted and results are cleared to 0.
  - The next start after release behaves normally.
- Timing: the full-adder cell uses gate delays of 50 per gate, with a worst case of 150 (XOR->AND->OR). The clock period must be >= 200 time units, and the bench runs at a period of 400.

Decomposition:
- Shared defines file serial_adder_defs:
  - state encodings S_IDLE=2'b00, S_RUN=2'b01, S_DONE=2'b10;
  - default WIDTH.
- One natural sub-module: instantiate the existing structuralFullAdder as the per-bit cell.
  - The behavioralFullAdder is swappable in for fast simulation; the port order is identical.
- Counter width is $clog2(WIDTH) bits, computed locally.

Test Plan:
- Reset: assert rst_n=0 mid-simulation -> busy=0, done=0, sum=8'h00, cout=0, overflow=0 asynchronously, without waiting for a clock edge.
- Basic add: a=8'h35, b=8'h4A, cin=0, start for 1 cycle -> busy high for 8 cycles; done pulses in the 9th cycle after the start edge; sum=8'h7F, cout=0, overflow=0.
- Carry/wrap: a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1, overflow=0. Then a=8'h00, b=8'h00, cin=1 -> sum=8'h01, cout=0.
- Signed overflow: a=8'h7F, b=8'h01 -> sum=8'h80, cout=0, overflow=1. Then a=8'h80, b=8'h80 -> sum=8'h00, cout=1, overflow=1.
- Handshake:
  - pulse start during RUN with different operands -> ignored, result of the first operation unchanged;
  - assert start in the DONE cycle -> the second operation runs immediately and its done arrives 9 cycles later;
  - sum holds the first result until then.
- Reset mid-operation: pull rst_n low 4 cycles after start, release, then add 8'h10+8'h20 -> no done pulse for the aborted operation; new result sum=8'h30, cout=0.
